// File: rtl/mac_stream_sched.sv
// Streams a stored J-word vector I times, pairing each beat with its row of mask bits,
// and waits for the downstream MAC to return a result between passes.
module mac_stream_sched #(
  parameter int unsigned J = 14,
  parameter int unsigned I = 7,
  parameter int unsigned A = 2,
  localparam int unsigned N  = I * J,
  localparam int unsigned AW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   vec_in,
  input  logic          vec_in_valid,
  input  logic          vec_in_last,
  input  logic          m_wr_en,
  input  logic [AW-1:0] m_wr_addr,
  input  logic [A-1:0]  m_wr_data,
  input  logic          start,
  input  logic          abort,
  input  logic          beta_tvalid,
  output logic [31:0]   vinput,
  output logic          vinput_tvalid,
  output logic          vinput_tlast,
  output logic [A-1:0]  M_row,
  output logic          M_row_tvalid,
  output logic          M_row_tlast,
  output logic          busy,
  output logic          done,
  output logic          vec_loaded
);

  localparam int unsigned KW = (J > 1) ? $clog2(J) : 1;
  localparam int unsigned PW = (I > 1) ? $clog2(I) : 1;
  localparam logic [KW-1:0] KLast = KW'(J - 1);
  localparam logic [PW-1:0] PLast = PW'(I - 1);

  typedef enum logic [1:0] {StIdle, StStream, StWait, StDone} state_e;

  state_e        state_q;
  logic [31:0]   vec_mem  [J];
  logic [A-1:0]  mask_mem [N];
  logic [KW-1:0] wptr_q, k_q, beat_k;
  logic [PW-1:0] pass_q, beat_p;
  logic [AW-1:0] beat_addr;
  logic          vec_loaded_q, drop_q;
  logic [31:0]   vinput_q;
  logic [A-1:0]  m_row_q;
  logic          tvalid_q, tlast_q;
  logic          vec_we, mask_we;

  // drop_q marks an overlong load: words after J-1 are discarded until vec_in_last.
  assign vec_we  = (state_q == StIdle) && vec_in_valid && !drop_q;
  assign mask_we = (state_q == StIdle) && m_wr_en && (32'(m_wr_addr) < N);

  always_ff @(posedge clk) begin
    if (vec_we) begin
      vec_mem[wptr_q] <= vec_in;
    end
    if (mask_we) begin
      mask_mem[m_wr_addr] <= m_wr_data;
    end
  end

  // Coordinates of the beat that would be issued on the next edge.
  always_comb begin
    beat_p = pass_q;
    beat_k = '0;
    case (state_q)
      StStream: beat_k = (k_q == KLast) ? k_q : k_q + 1'b1;
      StWait:   beat_p = (pass_q == PLast) ? pass_q : pass_q + 1'b1;
      default:  beat_p = '0;
    endcase
  end

  assign beat_addr = AW'(32'(beat_p) * J + 32'(beat_k));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      wptr_q       <= '0;
      k_q          <= '0;
      pass_q       <= '0;
      vec_loaded_q <= 1'b0;
      drop_q       <= 1'b0;
      vinput_q     <= '0;
      m_row_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
    end else begin
      if (vec_we) begin
        if (wptr_q == '0) begin
          vec_loaded_q <= 1'b0;
        end
        if (wptr_q == KLast) begin
          vec_loaded_q <= 1'b1;
          wptr_q       <= '0;
          drop_q       <= !vec_in_last;
        end else if (vec_in_last) begin
          wptr_q <= '0;
        end else begin
          wptr_q <= wptr_q + 1'b1;
        end
      end else if ((state_q == StIdle) && vec_in_valid && vec_in_last) begin
        drop_q <= 1'b0;
      end

      if (abort) begin
        state_q  <= StIdle;
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (start && vec_loaded_q) begin
              state_q  <= StStream;
              pass_q   <= '0;
              k_q      <= '0;
              drop_q   <= 1'b0;
              vinput_q <= vec_mem[beat_k];
              m_row_q  <= mask_mem[beat_addr];
              tvalid_q <= 1'b1;
              tlast_q  <= (beat_k == KLast);
            end
          end
          StStream: begin
            if (k_q == KLast) begin
              state_q  <= StWait;
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
            end else begin
              k_q      <= beat_k;
              vinput_q <= vec_mem[beat_k];
              m_row_q  <= mask_mem[beat_addr];
              tvalid_q <= 1'b1;
              tlast_q  <= (beat_k == KLast);
            end
          end
          StWait: begin
            if (beta_tvalid) begin
              if (pass_q == PLast) begin
                state_q <= StDone;
              end else begin
                state_q  <= StStream;
                pass_q   <= beat_p;
                k_q      <= '0;
                vinput_q <= vec_mem[beat_k];
                m_row_q  <= mask_mem[beat_addr];
                tvalid_q <= 1'b1;
                tlast_q  <= (beat_k == KLast);
              end
            end
          end
          StDone:  state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign vinput        = vinput_q;
  assign vinput_tvalid = tvalid_q;
  assign vinput_tlast  = tlast_q;
  assign M_row         = m_row_q;
  assign M_row_tvalid  = tvalid_q;
  assign M_row_tlast   = tlast_q;
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);
  assign vec_loaded    = vec_loaded_q;

endmodule

// File: tb/tb_mac_stream_sched.sv
// Scoreboard bench for mac_stream_sched: stimulus queues expected beats, a negedge
// monitor pops and compares every valid beat and counts done pulses.
module tb_mac_stream_sched;

  localparam int J = 14;
  localparam int I = 7;
  localparam int A = 2;
  localparam int N = I * J;

  logic        clk, rst;
  logic [31:0] vec_in;
  logic        vec_in_valid, vec_in_last;
  logic        m_wr_en;
  logic [6:0]  m_wr_addr;
  logic [1:0]  m_wr_data;
  logic        start, abort, beta_tvalid;
  logic [31:0] vinput;
  logic        vinput_tvalid, vinput_tlast;
  logic [1:0]  M_row;
  logic        M_row_tvalid, M_row_tlast;
  logic        busy, done, vec_loaded;

  mac_stream_sched #(.J(J), .I(I), .A(A)) dut (
    .clk          (clk),
    .rst          (rst),
    .vec_in       (vec_in),
    .vec_in_valid (vec_in_valid),
    .vec_in_last  (vec_in_last),
    .m_wr_en      (m_wr_en),
    .m_wr_addr    (m_wr_addr),
    .m_wr_data    (m_wr_data),
    .start        (start),
    .abort        (abort),
    .beta_tvalid  (beta_tvalid),
    .vinput       (vinput),
    .vinput_tvalid(vinput_tvalid),
    .vinput_tlast (vinput_tlast),
    .M_row        (M_row),
    .M_row_tvalid (M_row_tvalid),
    .M_row_tlast  (M_row_tlast),
    .busy         (busy),
    .done         (done),
    .vec_loaded   (vec_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] v;
    logic [1:0]  m;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       mon_e;
  int          errors = 0;
  int          checks = 0;
  int          job_beats = 0;
  int          job_tlast = 0;
  int          done_cnt = 0;
  int          d0;
  logic [31:0] cap_v;
  logic [1:0]  cap_m;
  logic [31:0] tb_vec  [J];
  logic [1:0]  tb_mask [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && vinput_tvalid) begin
      check("m_row_tvalid", M_row_tvalid, 1);
      check("m_row_tlast", M_row_tlast, vinput_tlast);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got vinput=%0d, expected no beat at %0t", vinput, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("vinput", vinput, mon_e.v);
        check("m_row", M_row, mon_e.m);
        check("tlast", vinput_tlast, mon_e.l);
      end
      if (job_beats == 33) begin
        cap_v = vinput;
        cap_m = M_row;
      end
      job_beats++;
      if (vinput_tlast) job_tlast++;
    end
    if (!rst && done) done_cnt++;
  end

  // Downstream MAC model: return beta_tvalid three cycles after each tlast beat.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && vinput_tvalid && vinput_tlast) begin
        @(posedge clk);
        @(posedge clk);
        #1 beta_tvalid = 1'b1;
        @(posedge clk);
        #1 beta_tvalid = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_vec(input int n, input int base, input bit with_last);
    for (int i = 0; i < n; i++) begin
      vec_in       = 32'(base + i);
      vec_in_valid = 1'b1;
      vec_in_last  = with_last && (i == n - 1);
      tick();
    end
    vec_in_valid = 1'b0;
    vec_in_last  = 1'b0;
  endtask

  task automatic push_beats(input int n);
    beat_t b;
    for (int idx = 0; idx < n; idx++) begin
      b.v = tb_vec[idx % J];
      b.m = tb_mask[idx];
      b.l = ((idx % J) == J - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic start_job();
    job_beats = 0;
    job_tlast = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int base);
    for (int c = 0; c < budget && done_cnt == base; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("done_pulses", done_cnt - base, 1);
  endtask

  task automatic job_checks();
    check("job_beats", job_beats, N);
    check("job_tlast", job_tlast, I);
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    vec_in = '0; vec_in_valid = 0; vec_in_last = 0;
    m_wr_en = 0; m_wr_addr = '0; m_wr_data = '0;
    start = 0; abort = 0; beta_tvalid = 0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_vinput", vinput, 0);
    check("rst_m_row", M_row, 0);
    check("rst_tvalid", vinput_tvalid, 0);
    check("rst_tlast", vinput_tlast, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_vec_loaded", vec_loaded, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Start with no vector loaded is ignored.
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    @(negedge clk) check("busy_no_vec", busy, 0);

    // Full job.
    for (int k = 0; k < J; k++) tb_vec[k] = 32'(k + 1);
    load_vec(J, 1, 1);
    check("vec_loaded_full", vec_loaded, 1);
    for (int a = 0; a < N; a++) begin
      tb_mask[a] = 2'(((a / J) + (a % J)) % 4);
      m_wr_en = 1'b1; m_wr_addr = 7'(a); m_wr_data = tb_mask[a];
      tick();
    end
    m_wr_addr = 7'd100; m_wr_data = 2'd3; tick();
    m_wr_en = 1'b0;
    push_beats(N);
    d0 = done_cnt;
    start_job();
    @(negedge clk);
    check("first_beat_valid", vinput_tvalid, 1);
    check("busy_streaming", busy, 1);
    wait_done(600, d0);
    job_checks();
    check("beat_p2k5_vinput", cap_v, 6);
    check("beat_p2k5_mrow", cap_m, 3);

    // Stray beta/start/mask/vector inputs while busy change nothing.
    push_beats(N);
    d0 = done_cnt;
    start_job();
    beta_tvalid = 1'b1; start = 1'b1;
    m_wr_en = 1'b1; m_wr_addr = '0; m_wr_data = 2'd3;
    vec_in_valid = 1'b1; vec_in = 32'hdead;
    tick();
    beta_tvalid = 1'b0; start = 1'b0; m_wr_en = 1'b0; vec_in_valid = 1'b0;
    wait_done(600, d0);
    job_checks();

    // Abort at pass 3, k 7.
    push_beats(3 * J + 8);
    d0 = done_cnt;
    start_job();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      #1;
      if (job_beats >= 3 * J + 8) break;
    end
    check("abort_point", job_beats, 3 * J + 8);
    abort = 1'b1; tick(); abort = 1'b0;
    @(negedge clk);
    check("abort_tvalid", vinput_tvalid, 0);
    check("abort_tlast", vinput_tlast, 0);
    check("abort_busy", busy, 0);
    repeat (8) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_queue", exp_q.size(), 0);
    check("abort_vec_loaded", vec_loaded, 1);
    #1;
    abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
    @(negedge clk) check("abort_beats_start", busy, 0);
    #1;
    push_beats(N);
    d0 = done_cnt;
    start_job();
    wait_done(600, d0);
    job_checks();

    // Short load leaves no vector.
    #1;
    load_vec(10, 101, 1);
    check("short_vec_loaded", vec_loaded, 0);
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 4; c++) @(negedge clk) check("short_busy", busy, 0);

    // Overlong load keeps the first J words.
    #1;
    load_vec(20, 201, 0);
    check("long_vec_loaded", vec_loaded, 1);
    for (int k = 0; k < J; k++) tb_vec[k] = 32'(201 + k);
    push_beats(N);
    d0 = done_cnt;
    start_job();
    wait_done(600, d0);
    job_checks();

    // Short asynchronous reset while waiting for beta.
    #1;
    push_beats(N);
    start_job();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      #1;
      if (job_tlast >= 1) break;
    end
    @(posedge clk);
    #1;
    check("in_wait_busy", busy, 1);
    check("in_wait_tvalid", vinput_tvalid, 0);
    rst = 1'b1;
    #2;
    check("arst_vinput", vinput, 0);
    check("arst_m_row", M_row, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_tvalid", vinput_tvalid, 0);
    check("arst_vec_loaded", vec_loaded, 0);
    #1 rst = 1'b0;
    exp_q.delete();
    tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_start_ignored", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_stream_sched.md
MAC_STREAM_SCHED -- requirements
Module: mac_stream_sched

Interface
REQ-001 Parameter J, default 14: vector length, i.e. beats per pass.
REQ-002 Parameter I, default 7: passes per job, one M row-block per pass.
REQ-003 Parameter A, default 2: number of parallel accumulators, i.e. width of M_row.
REQ-004 The block SHALL have one clock, clk; reset is asynchronous and active-high, port rst.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 vec_in  input  32  vector word to load.
REQ-008 vec_in_valid  input  1  vec_in qualifier.
REQ-009 vec_in_last  input  1  final vector word of a load.
REQ-010 m_wr_en  input  1  mask memory write strobe.
REQ-011 m_wr_addr  input  clog2(I*J)  mask address, pass*J+k.
REQ-012 m_wr_data  input  A  mask bits, one per accumulator.
REQ-013 start  input  1  single-cycle job start.
REQ-014 abort  input  1  synchronous job cancel.
REQ-015 beta_tvalid  input  1  pass result returned from the downstream MAC.
REQ-016 vinput  output  32  streamed vector word.
REQ-017 vinput_tvalid  output  1  beat valid.
REQ-018 vinput_tlast  output  1  last beat of a pass.
REQ-019 M_row  output  A  mask bits for the current beat.
REQ-020 M_row_tvalid  output  1  always equal to vinput_tvalid.
REQ-021 M_row_tlast  output  1  always equal to vinput_tlast.
REQ-022 busy  output  1  high in every state except IDLE.
REQ-023 done  output  1  one-cycle pulse at job completion.
REQ-024 vec_loaded  output  1  a complete J-word vector is held.

Function
REQ-025 The state machine SHALL have the states IDLE, STREAM, WAIT, DONE.
REQ-026 Vector load SHALL be accepted in IDLE only; each vec_in_valid writes vec[wptr] and then increments wptr.
REQ-027 wptr SHALL return to 0 on vec_in_last, or after word J-1, whichever comes first; words beyond J-1 are discarded.
REQ-028 vec_loaded SHALL set when word J-1 is written; it SHALL clear on the first vec_in_valid of a new load.
REQ-029 A load terminated by vec_in_last before J words SHALL leave vec_loaded = 0.
REQ-030 Mask writes SHALL be accepted in IDLE only; writes in other states, or with m_wr_addr >= I*J, SHALL be ignored.
REQ-031 Transition IDLE->STREAM SHALL occur when start=1 and vec_loaded=1, setting pass=0 and k=0.
REQ-032 start SHALL be ignored in all other cases.
REQ-033 The outputs SHALL be registered; the first beat appears on the cycle after start is sampled.
REQ-034 In STREAM, one beat SHALL be issued per cycle with no gaps: vinput=vec[k], M_row=mask[pass*J+k], tvalid=1.
REQ-035 tlast SHALL be 1 only when k=J-1.
REQ-036 After the tlast beat the block SHALL go to WAIT, with tvalid=0.
REQ-037 In WAIT, beta_tvalid=1 SHALL cause: if pass=I-1, go to DONE; otherwise pass+1, k=0, go to STREAM, with the next beat on the following cycle.
REQ-038 beta_tvalid outside WAIT SHALL be ignored.
REQ-039 DONE SHALL last exactly one cycle with done=1, then go to IDLE.
REQ-040 abort=1 in any state SHALL force IDLE on the next edge, with tvalid=0, tlast=0 and no done pulse.
REQ-041 abort SHALL preserve the vec and mask contents and vec_loaded.
REQ-042 When start and abort are high in the same cycle, abort SHALL win.
REQ-043 When beta_tvalid and abort are high in the same cycle, abort SHALL win.
REQ-044 Latency per pass SHALL be J beat cycles plus the WAIT duration.
REQ-045 Total beats per job SHALL be exactly I*J, with exactly I tlast beats.

Reset
REQ-046 While rst=1, the block SHALL hold: state=IDLE, wptr=0, k=0, pass=0, vec_loaded=0, vinput=0, M_row=0, all tvalid/tlast=0, busy=0, done=0.
REQ-047 Reset asserted mid-job SHALL act immediately and asynchronously; memory contents are don't-care after reset.
REQ-048 The first start after reset SHALL be ignored until a new full vector load completes.

Verification
REQ-049 Full job: load vec[k]=k+1 for k=0..13; write mask[p*14+k]=(p+k)%4; pulse start; return beta_tvalid 3 cycles after each tlast -> 98 beats, 7 tlast beats, beat (p=2, k=5) gives vinput=6 and M_row=3, then one done pulse.
REQ-050 Short load: 10 words with vec_in_last on the 10th, then start -> vec_loaded=0, no beats issued, busy stays 0.
REQ-051 Overlong load: 20 words without last -> vec holds words 1..14, words 15..20 are dropped, vec_loaded=1.
REQ-052 Abort mid-stream: abort at pass 3, k=7 -> tvalid=0 on the next cycle, no done pulse; a new start replays from pass 0, k=0 with unchanged data.
REQ-053 Stray inputs: beta_tvalid during STREAM, and start/m_wr_en while busy -> no effect; the beat sequence is identical to REQ-049.
REQ-054 Async reset mid-WAIT: rst pulse shorter than a clock period -> outputs 0 without a clock edge, vec_loaded=0.
